alu_serial_ctrl: RTL and testbench

//  Bit-serial N-bit ALU sequencer built around one ALU1Bit slice.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_serial_ctrl_if.sv | 25 ++
 rtl/alu_serial_ctrl_slice.sv | 29 ++
 rtl/alu_serial_ctrl.sv | 105 ++++++++++
 tb/tb_alu_serial_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, sequencer state type and op classification for the bit-serial ALU.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return op[1:0] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between an op issuer and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, cout, overflow, zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout, overflow, zero
   );
endinterface

// File: rtl/alu_serial_ctrl_slice.sv
// One-bit ALU slice: AND/OR/ADD with optional b inversion, plus a pass-through 'less' input for SLT.
module ALU1Bit (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       less,
   input  logic [2:0] op,
   output logic       result,
   output logic       cout,
   output logic       set
);
   logic bb;
   logic sum;

   assign bb   = b ^ op[2];
   assign sum  = a ^ bb ^ cin;
   assign cout = (a & bb) | (cin & (a ^ bb));
   assign set  = sum;

   always_comb begin
      result = 1'b0;
      case (op[1:0])
         2'b00:   result = a & bb;
         2'b01:   result = a | bb;
         2'b10:   result = sum;
         default: result = less;
      endcase
   end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU sequencer: streams operands LSB-first through one ALU1Bit slice.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_serial_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [2:0]         op_r;
   logic               carry;
   logic               cin_msb;
   logic               cout_msb;
   logic               set_msb;
   logic               s_res;
   logic               s_cout;
   logic               s_set;
   logic [WIDTH-1:0]   res_final;

   ALU1Bit u_slice (
      .a      (a_sr[0]),
      .b      (b_sr[0]),
      .cin    (carry),
      .less   (1'b0),
      .op     (op_r),
      .result (s_res),
      .cout   (s_cout),
      .set    (s_set)
   );

   // SLT folds the overflow back into the sign so the compare stays correct when a-b wraps.
   always_comb begin
      res_final = res_sr;
      if (op_r[1:0] == 2'b11)
         res_final = {{(WIDTH-1){1'b0}}, set_msb ^ cin_msb ^ cout_msb};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         a_sr         <= '0;
         b_sr         <= '0;
         res_sr       <= '0;
         op_r         <= '0;
         carry        <= 1'b0;
         cin_msb      <= 1'b0;
         cout_msb     <= 1'b0;
         set_msb      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.result   <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
         bus.zero     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.a;
                  b_sr     <= bus.b;
                  op_r     <= bus.op;
                  carry    <= bus.op[2];
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               carry  <= s_cout;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {s_res, res_sr[WIDTH-1:1]};
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  cin_msb  <= carry;
                  cout_msb <= s_cout;
                  set_msb  <= s_set;
                  bus.busy <= 1'b0;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               bus.done     <= 1'b1;
               bus.result   <= res_final;
               bus.zero     <= (res_final == '0);
               bus.cout     <= is_arith(op_r) ? cout_msb : 1'b0;
               bus.overflow <= is_arith(op_r) ? (cin_msb ^ cout_msb) : 1'b0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed table-driven bench for the bit-serial ALU sequencer at WIDTH=8.
module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   alu_serial_ctrl_if #(.WIDTH(W)) bus ();

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       cout;
      logic       ovf;
      logic       zero;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Presents one request, returns cycles from the accept edge to the done pulse.
   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      lat = 0;
      while (lat < 40 && !bus.done) begin
         @(posedge clk); #1;
         lat++;
      end
      check("done_seen", {31'd0, bus.done}, 32'd1);
   endtask

   initial begin
      int lat;
      int ndone;

      errors = 0;
      checks = 0;
      vecs[0]  = '{"add_7f_01",  OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{"sub_eq",     OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{"sub_0_1",    OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"slt_80_01",  OP_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"slt_7f_80",  OP_SLT, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{"slt_eq",     OP_SLT, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{"and",        OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"or",         OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"and_nb",     3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"or_nb",      3'b101, 8'hF0, 8'h3C, 8'hF3, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"add_wrap",   OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{"add_neg_ov", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{"slt011_pos", 3'b011, 8'h40, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{"slt011_neg", 3'b011, 8'hC0, 8'hC0, 8'h01, 1'b0, 1'b0, 1'b0};

      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",   {31'd0, bus.busy},     32'd0);
      check("rst_done",   {31'd0, bus.done},     32'd0);
      check("rst_result", {24'd0, bus.result},   32'd0);
      check("rst_zero",   {31'd0, bus.zero},     32'd1);
      check("rst_cout",   {31'd0, bus.cout},     32'd0);
      check("rst_ovf",    {31'd0, bus.overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check({vecs[i].name, "_res"},  {24'd0, bus.result},   {24'd0, vecs[i].res});
         check({vecs[i].name, "_cout"}, {31'd0, bus.cout},     {31'd0, vecs[i].cout});
         check({vecs[i].name, "_ovf"},  {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
         check({vecs[i].name, "_zero"}, {31'd0, bus.zero},     {31'd0, vecs[i].zero});
         check({vecs[i].name, "_lat"},  lat, 32'd9);
         check({vecs[i].name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
         @(posedge clk); #1;
         check({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
         check({vecs[i].name, "_hold"}, {24'd0, bus.result}, {24'd0, vecs[i].res});
      end

      // start held high throughout RUN with different operands must be ignored
      bus.op = OP_ADD; bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.op = OP_OR; bus.a = 8'hAA; bus.b = 8'h55;
      lat = 0;
      while (lat < 40 && !bus.done) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      check("spam_done_seen", {31'd0, bus.done}, 32'd1);
      check("spam_lat", lat, 32'd9);
      check("spam_res", {24'd0, bus.result}, 32'h46);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("spam_single_done", ndone, 32'd0);
      check("spam_hold", {24'd0, bus.result}, 32'h46);

      // back-to-back: next request presented while done is high
      run_op(OP_ADD, 8'h10, 8'h20, lat);
      check("b2b_first_res", {24'd0, bus.result}, 32'h30);
      run_op(OP_SUB, 8'h10, 8'h20, lat);
      check("b2b_second_res", {24'd0, bus.result}, 32'hF0);
      check("b2b_second_lat", lat, 32'd9);
      check("b2b_second_cout", {31'd0, bus.cout}, 32'd0);
      @(posedge clk); #1;

      // asynchronous reset while cnt==3 of an ADD
      bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy",   {31'd0, bus.busy},     32'd0);
      check("arst_done",   {31'd0, bus.done},     32'd0);
      check("arst_result", {24'd0, bus.result},   32'd0);
      check("arst_zero",   {31'd0, bus.zero},     32'd1);
      check("arst_cout",   {31'd0, bus.cout},     32'd0);
      check("arst_ovf",    {31'd0, bus.overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("arst_no_done", ndone, 32'd0);
      run_op(OP_ADD, 8'h55, 8'h2B, lat);
      check("arst_next_res", {24'd0, bus.result}, 32'h80);
      check("arst_next_ovf", {31'd0, bus.overflow}, 32'd1);
      check("arst_next_lat", lat, 32'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
